// File: rtl/fp_addsub_param_if.sv
// Request/response bundle for fp_addsub_param: operands and strobe in,
// status, result and exception flags out.
interface fp_addsub_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         op_sub;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         ready;
    logic [W-1:0] sum;
    logic         flag_invalid;
    logic         flag_overflow;
    logic         flag_inexact;

    modport master (
        output start, op_sub, opa, opb,
        input  busy, ready, sum, flag_invalid, flag_overflow, flag_inexact
    );

    modport slave (
        input  start, op_sub, opa, opb,
        output busy, ready, sum, flag_invalid, flag_overflow, flag_inexact
    );
endinterface

// File: rtl/fp_addsub_param.sv
// Parameterised floating-point adder/subtractor with an iterative datapath:
// one-bit-per-cycle alignment and normalisation, round-to-nearest-even.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic              clk,
    input logic              rst,
    fp_addsub_param_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 4;
    localparam int XW   = EXP_W + 2;
    localparam int BIAS = 2**(EXP_W-1) - 1;

    localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
    localparam logic signed [XW-1:0] EMIN   = XW'(1 - BIAS);
    localparam logic signed [XW-1:0] EOVF   = XW'(2**EXP_W - 1 - BIAS);
    localparam logic signed [XW-1:0] FAR    = XW'(MAN_W + 3);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        IDLE, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, DONE
    } state_t;

    state_t state, state_nx;

    logic [W-1:0]         a_w, b_w;
    logic                 sa, sb, rs;
    logic signed [XW-1:0] ea, eb, re;
    logic [MW-1:0]        ma, mb;
    logic [MW:0]          rm;
    logic [MAN_W:0]       rmant;
    logic                 inx_r;
    logic [W-1:0]         sum_r;
    logic                 f_inv, f_ovf, f_inx;

    logic [EXP_W-1:0] fa_exp, fb_exp;
    logic [MAN_W-1:0] fa_man, fb_man;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;

    assign fa_exp = a_w[W-2:MAN_W];
    assign fb_exp = b_w[W-2:MAN_W];
    assign fa_man = a_w[MAN_W-1:0];
    assign fb_man = b_w[MAN_W-1:0];

    assign a_nan  = (&fa_exp) & (|fa_man);
    assign b_nan  = (&fb_exp) & (|fb_man);
    assign a_inf  = (&fa_exp) & ~(|fa_man);
    assign b_inf  = (&fb_exp) & ~(|fb_man);
    assign a_zero = ~(|fa_exp) & ~(|fa_man);
    assign b_zero = ~(|fb_exp) & ~(|fb_man);
    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    logic signed [XW-1:0] d_ab, d_ba;
    assign d_ab = ea - eb;
    assign d_ba = eb - ea;

    // Kept mantissa is {hidden, fraction}; bits [2:0] are guard/round/sticky.
    logic             rnd_up;
    logic [MAN_W+1:0] rnd;
    assign rnd_up = rm[2] & (rm[1] | rm[0] | rm[3]);
    assign rnd    = {1'b0, rm[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};

    logic [EXP_W-1:0] pk_exp;
    assign pk_exp = rmant[MAN_W] ? EXP_W'(re + BIAS_X) : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = UNPACK;
            UNPACK:  state_nx = SPECIAL;
            SPECIAL: state_nx = special ? DONE : ALIGN;
            ALIGN:   if (ea == eb) state_nx = ADD;
            ADD:     state_nx = NORM;
            NORM:    if (!rm[MW] && (rm[MW-1] || re == EMIN || rm == '0)) state_nx = ROUND;
            ROUND:   state_nx = PACK;
            PACK:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= '0;
            f_inv <= 1'b0;
            f_ovf <= 1'b0;
            f_inx <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_w   <= bus.opa;
                    b_w   <= {bus.opb[W-1] ^ bus.op_sub, bus.opb[W-2:0]};
                    f_inv <= 1'b0;
                    f_ovf <= 1'b0;
                    f_inx <= 1'b0;
                end
                UNPACK: begin
                    sa <= a_w[W-1];
                    sb <= b_w[W-1];
                    ea <= (fa_exp == '0) ? EMIN : signed'({2'b00, fa_exp}) - BIAS_X;
                    eb <= (fb_exp == '0) ? EMIN : signed'({2'b00, fb_exp}) - BIAS_X;
                    ma <= {fa_exp != '0, fa_man, 3'b000};
                    mb <= {fb_exp != '0, fb_man, 3'b000};
                end
                SPECIAL: begin
                    if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) begin
                        sum_r <= QNAN;
                        f_inv <= 1'b1;
                    end else if (a_inf)              sum_r <= a_w;
                    else if (b_inf)                  sum_r <= b_w;
                    else if (a_zero && b_zero)       sum_r <= {sa & sb, {(W-1){1'b0}}};
                    else if (b_zero)                 sum_r <= a_w;
                    else if (a_zero)                 sum_r <= b_w;
                end
                ALIGN: begin
                    // Differences beyond the guard/round span collapse to a lone sticky bit.
                    if (ea < eb) begin
                        if (d_ba > FAR) begin
                            ma <= {{(MW-1){1'b0}}, |ma};
                            ea <= eb;
                        end else begin
                            ma <= {1'b0, ma[MW-1:2], ma[1] | ma[0]};
                            ea <= ea + ONE_X;
                        end
                    end else if (eb < ea) begin
                        if (d_ab > FAR) begin
                            mb <= {{(MW-1){1'b0}}, |mb};
                            eb <= ea;
                        end else begin
                            mb <= {1'b0, mb[MW-1:2], mb[1] | mb[0]};
                            eb <= eb + ONE_X;
                        end
                    end
                end
                ADD: begin
                    re <= ea;
                    if (sa == sb) begin
                        rm <= {1'b0, ma} + {1'b0, mb};
                        rs <= sa;
                    end else if (ma >= mb) begin
                        rm <= {1'b0, ma - mb};
                        rs <= (ma == mb) ? 1'b0 : sa;
                    end else begin
                        rm <= {1'b0, mb - ma};
                        rs <= sb;
                    end
                end
                NORM: begin
                    if (rm[MW]) begin
                        rm <= {1'b0, rm[MW:2], rm[1] | rm[0]};
                        re <= re + ONE_X;
                    end else if (!rm[MW-1] && re != EMIN && rm != '0) begin
                        rm <= {rm[MW-1:0], 1'b0};
                        re <= re - ONE_X;
                    end
                end
                ROUND: begin
                    inx_r <= |rm[2:0];
                    if (rnd[MAN_W+1]) begin
                        rmant <= rnd[MAN_W+1:1];
                        re    <= re + ONE_X;
                    end else begin
                        rmant <= rnd[MAN_W:0];
                    end
                end
                PACK: begin
                    if (re >= EOVF) begin
                        sum_r <= {rs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        f_ovf <= 1'b1;
                        f_inx <= 1'b1;
                    end else begin
                        sum_r <= {rs, pk_exp, rmant[MAN_W-1:0]};
                        f_inx <= inx_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.ready         = (state == DONE);
    assign bus.sum           = sum_r;
    assign bus.flag_invalid  = f_inv;
    assign bus.flag_overflow = f_ovf;
    assign bus.flag_inexact  = f_inx;
endmodule

// File: doc/fp_addsub_param.md
FP_ADDSUB_PARAM -- requirements
Module: fp_addsub_param

Interface
REQ-001 The block SHALL have the parameter EXP_W, default 8, exponent field width, legal range 4..11.
REQ-002 The block SHALL have the parameter MAN_W, default 23, stored fraction width, legal range 4..52.
REQ-003 The block SHALL use W = 1+EXP_W+MAN_W as the word width, with format {sign, biased exponent, fraction}.
REQ-004 The block SHALL use BIAS = 2^(EXP_W-1)-1.
REQ-005 Ports SHALL be:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  request strobe.
- op_sub  in  1  0 = opa+opb, 1 = opa-opb.
- opa  in  W  operand A.
- opb  in  W  operand B.
- busy  out  1  high from the cycle after acceptance until DONE.
- ready  out  1  one-cycle pulse when the result is valid.
- sum  out  W  result, held until the next ready.
- flag_invalid  out  1  NaN produced from non-NaN inputs, or any input NaN.
- flag_overflow  out  1  rounded result exceeded the maximum finite value.
- flag_inexact  out  1  guard, round or sticky bit was nonzero before rounding, or overflow occurred.

Function
REQ-006 Start SHALL be accepted only in IDLE; opa, opb and op_sub SHALL be captured on acceptance; start while busy SHALL be ignored.
REQ-007 op_sub=1 SHALL invert the sign of the captured opb before all other processing, including special cases.
REQ-008 The FSM SHALL have states IDLE, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, DONE.
REQ-009 FSM transitions SHALL be:
- IDLE -> UNPACK on start.
- SPECIAL -> DONE on a special case, else -> ALIGN.
- ALIGN loops until exponents are equal.
- NORM loops until the MSB is set or the minimum exponent is reached.
- All other states advance one per cycle.
- DONE -> IDLE.
REQ-010 The datapath mantissa SHALL be MAN_W+4 bits wide, {hidden, fraction, guard, round, sticky}, plus one carry bit.
REQ-011 Exponents SHALL be held signed, EXP_W+2 bits wide.
REQ-012 A denormal input SHALL use an exponent of 1-BIAS and a hidden bit of 0.
REQ-013 ALIGN SHALL shift the smaller-exponent mantissa right one bit per cycle, ORing shifted-out bits into sticky.
REQ-014 If the exponent difference exceeds MAN_W+3, ALIGN SHALL in a single cycle replace that mantissa with sticky = (mantissa != 0).
REQ-015 The worst-case latency from acceptance to ready SHALL be at most 2*MAN_W+16 cycles.
REQ-016 Special cases SHALL resolve in SPECIAL as follows:
- Any input NaN, or +inf + -inf, SHALL produce canonical qNaN {0, all-ones, 1 followed by zeros} with flag_invalid=1.
- inf + finite SHALL produce that inf.
- x + 0 SHALL produce x.
- 0 + 0 SHALL produce a sign equal to the AND of the input signs.
REQ-017 Effective subtraction SHALL subtract the smaller magnitude from the larger; the result sign SHALL be that of the larger magnitude.
REQ-018 An exact zero result SHALL be +0.
REQ-019 Carry-out SHALL shift right one bit, incrementing the exponent and preserving sticky.
REQ-020 Rounding SHALL be round-to-nearest-even; a mantissa overflow from rounding SHALL increment the exponent.
REQ-021 A result exponent >= 2^EXP_W-1-BIAS SHALL produce ±inf with flag_overflow=1 and flag_inexact=1.
REQ-022 A result below the normal range SHALL be packed as a denormal (exponent field 0), rounded in the same way.
REQ-023 Flags SHALL be valid with ready and held with sum; they SHALL be cleared on the next acceptance.

Reset
REQ-024 While rst=1 at a clock edge the block SHALL go to IDLE and SHALL set busy=0, ready=0, sum=0 and all flags to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no ready pulse.
REQ-026 A start sampled in the same cycle as rst=1 SHALL be ignored.

Verification (default parameters)
REQ-027 The bench SHALL cover: opa=0x3F800000, opb=0x3F800000, op_sub=0 -> sum=0x40000000, all flags 0, exactly one ready pulse.
REQ-028 The bench SHALL cover: opa=0x3F800000, opb=0x3F800000, op_sub=1 -> sum=0x00000000 (+0), flags 0.
REQ-029 The bench SHALL cover: opa=0x7F800000, opb=0xFF800000, op_sub=0 -> sum=0x7FC00000, flag_invalid=1.
REQ-030 The bench SHALL cover: opa=opb=0x7F7FFFFF, op_sub=0 -> sum=0x7F800000, flag_overflow=1, flag_inexact=1.
REQ-031 The bench SHALL cover: opa=0x3F800000, opb=0x33800000 (2^-24) -> sum=0x3F800000, flag_inexact=1 (tie to even).
REQ-032 The bench SHALL cover: opa=0x00400000, opb=0x00400000 -> sum=0x00800000 (denormal to normal).
REQ-033 The bench SHALL cover: start then rst=1 three cycles later -> no ready pulse, busy=0, and a subsequent start completes correctly.
REQ-034 The bench SHALL cover EXP_W=5, MAN_W=10: 0x3C00+0x3C00 -> 0x4000; and the latency bound checked for an exponent difference of 30.
